// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped I/O controller for the MineCPU data port (port b).
// It decodes the window 0xFFFF_FF00-0xFFFF_FFFF. Read data is combinational.
// Register writes, clear-on-read and FIFO pops happen on the clkb edge.
//
// Ports:
//   clkb, rst        clock; synchronous active-high reset
//   addrb            byte address (word aligned)
//   write_datab, web store data and store strobe
//   reb              load strobe; qualifies read side effects
//   io_hit           address lies inside the I/O window
//   datab_io         read data; 0 on miss or unmapped offset
//   sw_in            switch levels, 8 bits per bank
//   bt_in            raw button levels
//   kb_idx           {key_valid, key_code[3:0]}
//   led_out, seg_out LED and seven-segment registers
//
// Build option: define MMIO_TIMER_EN to map a free-running cycle counter at
// offset 0x44. Without it, that offset is unmapped.
module mmio_hub #(
  parameter int SW_NUM   = 3,
  parameter int LED_NUM  = 2,
  parameter int BT_NUM   = 5,
  parameter int KB_DEPTH = 4
) (
  input  logic                  clkb,
  input  logic                  rst,
  input  logic [31:0]           addrb,
  input  logic [31:0]           write_datab,
  input  logic                  web,
  input  logic                  reb,
  output logic                  io_hit,
  output logic [31:0]           datab_io,
  input  logic [8*SW_NUM-1:0]   sw_in,
  input  logic [BT_NUM-1:0]     bt_in,
  input  logic [4:0]            kb_idx,
  output logic [8*LED_NUM-1:0]  led_out,
  output logic [31:0]           seg_out
);

  localparam int PW = $clog2(KB_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] W_SEG    = 6'd12;
  localparam logic [5:0] W_BTLVL  = 6'd13;
  localparam logic [5:0] W_BTEVT  = 6'd14;
  localparam logic [5:0] W_KBDATA = 6'd15;
  localparam logic [5:0] W_KBSTAT = 6'd16;
  localparam logic [5:0] W_TIMER  = 6'd17;

  logic [5:0] widx;
  logic       sel_ok;
  logic       wr_en;
  logic       rd_fx;

  assign io_hit = (addrb[31:8] == 24'hFFFFFF);
  assign widx   = addrb[7:2];
  // A byte-misaligned address matches no register.
  assign sel_ok = io_hit && (addrb[1:0] == 2'b00);
  assign wr_en  = sel_ok && web;
  // A simultaneous store suppresses every read side effect.
  assign rd_fx  = sel_ok && reb && !web;

  // Stage p0/p1: two-flop synchronisers
  logic [BT_NUM-1:0] bt_p0, bt_p1;
  logic [4:0]        kb_p0, kb_p1;
  // Stage p2: delayed copy for edge detection
  logic [BT_NUM-1:0] bt_p2;
  logic              kb_vld_p2;

  always_ff @(posedge clkb) begin
    if (rst) begin
      bt_p0     <= '0;
      bt_p1     <= '0;
      bt_p2     <= '0;
      kb_p0     <= '0;
      kb_p1     <= '0;
      kb_vld_p2 <= 1'b0;
    end else begin
      bt_p0     <= bt_in;
      bt_p1     <= bt_p0;
      bt_p2     <= bt_p1;
      kb_p0     <= kb_idx;
      kb_p1     <= kb_p0;
      kb_vld_p2 <= kb_p1[4];
    end
  end

  logic [BT_NUM-1:0] bt_rise;
  logic              kb_push;
  assign bt_rise = bt_p1 & ~bt_p2;
  assign kb_push = kb_p1[4] && !kb_vld_p2;

  // LED and seven-segment registers
  always_ff @(posedge clkb) begin
    if (rst) begin
      led_out <= '0;
      seg_out <= '0;
    end else begin
      for (int i = 0; i < LED_NUM; i++)
        if (wr_en && widx == 6'(8 + i))
          led_out[8*i +: 8] <= write_datab[7:0];
      if (wr_en && widx == W_SEG)
        seg_out <= write_datab;
    end
  end

  // Sticky button events. A new edge overrides a clear of the same bit.
  logic [BT_NUM-1:0] bt_evt;
  logic [BT_NUM-1:0] bt_clr;

  always_comb begin
    bt_clr = '0;
    if (wr_en && widx == W_BTEVT)
      bt_clr = write_datab[BT_NUM-1:0];
    else if (rd_fx && widx == W_BTEVT)
      bt_clr = bt_evt;
  end

  always_ff @(posedge clkb) begin
    if (rst) bt_evt <= '0;
    else     bt_evt <= (bt_evt & ~bt_clr) | bt_rise;
  end

  // Keypad FIFO
  logic [3:0]    kb_mem [KB_DEPTH];
  logic [PW-1:0] kb_wr_ptr, kb_rd_ptr;
  logic [CW-1:0] kb_cnt;
  logic          kb_ovf;
  logic          kb_empty, kb_full, kb_pop, kb_wr, kb_drop, ovf_clr;

  assign kb_empty = (kb_cnt == '0);
  assign kb_full  = (kb_cnt == CW'(KB_DEPTH));
  assign kb_pop   = rd_fx && widx == W_KBDATA && !kb_empty;
  // When the FIFO is full, a pop in the same cycle frees the head slot.
  // The new key then goes into that slot, which becomes the tail.
  assign kb_wr    = kb_push && (!kb_full || kb_pop);
  assign kb_drop  = kb_push && kb_full && !kb_pop;
  assign ovf_clr  = rd_fx && widx == W_KBSTAT;

  always_ff @(posedge clkb) begin
    if (rst) begin
      kb_wr_ptr <= '0;
      kb_rd_ptr <= '0;
      kb_cnt    <= '0;
      kb_ovf    <= 1'b0;
    end else begin
      if (kb_wr)  kb_wr_ptr <= kb_wr_ptr + PW'(1);
      if (kb_pop) kb_rd_ptr <= kb_rd_ptr + PW'(1);
      case ({kb_wr, kb_pop})
        2'b10:   kb_cnt <= kb_cnt + CW'(1);
        2'b01:   kb_cnt <= kb_cnt - CW'(1);
        default: kb_cnt <= kb_cnt;
      endcase
      kb_ovf <= kb_drop || (kb_ovf && !ovf_clr);
    end
  end

  always_ff @(posedge clkb) begin
    if (kb_wr) kb_mem[kb_wr_ptr] <= kb_p1[3:0];
  end

`ifdef MMIO_TIMER_EN
  // On a load, the counter still advances on that same edge. The cycle
  // after the store therefore reads write_datab + 1.
  logic [31:0] timer;
  always_ff @(posedge clkb) begin
    if (rst)                         timer <= '0;
    else if (wr_en && widx == W_TIMER) timer <= write_datab + 32'd1;
    else                             timer <= timer + 32'd1;
  end
`endif

  // Read mux
  always_comb begin
    datab_io = '0;
    if (sel_ok) begin
      for (int i = 0; i < SW_NUM; i++)
        if (widx == 6'(i)) datab_io = {24'h0, sw_in[8*i +: 8]};
      for (int i = 0; i < LED_NUM; i++)
        if (widx == 6'(8 + i)) datab_io = {24'h0, led_out[8*i +: 8]};
      case (widx)
        W_SEG:    datab_io = seg_out;
        W_BTLVL:  datab_io = 32'(bt_p1);
        W_BTEVT:  datab_io = 32'(bt_evt);
        W_KBDATA: if (!kb_empty) datab_io = {23'h0, 1'b1, 4'h0, kb_mem[kb_rd_ptr]};
        W_KBSTAT: datab_io = {15'h0, kb_ovf, 6'h0, kb_full, kb_empty, 8'(kb_cnt)};
`ifdef MMIO_TIMER_EN
        W_TIMER:  datab_io = timer;
`endif
        default:  ;
      endcase
    end
  end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O controller for the MineCPU data port (port b). It decodes the 256-byte window `0xFFFF_FF00`–`0xFFFF_FFFF` and provides:
- a configurable number of switch inputs and LED outputs, plus the seven-segment register;
- sticky button-event capture;
- a buffered keypad event FIFO, so key presses are not lost between CPU polls.

Read data is combinational from the address, for the memory mux. All side effects (register writes, clear-on-read, FIFO pop) take effect on the `clkb` edge.

## Interface
Parameters:
- `SW_NUM`, 3: switch banks, 1–8, 8 bits each.
- `LED_NUM`, 2: LED banks, 1–4, 8 bits each.
- `BT_NUM`, 5: buttons, 1–8.
- `KB_DEPTH`, 4: keypad FIFO entries; power of two, 2–128.

Ports:
- `clkb` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `addrb` input 32: byte address, word aligned.
- `write_datab` input 32: store data.
- `web` input 1: store strobe.
- `reb` input 1: load strobe; qualifies read side effects.
- `io_hit` output 1: high when `addrb[31:8]==24'hFFFFFF`.
- `datab_io` output 32: read data; 0 when there is no hit or the offset is unmapped.
- `sw_in` input `8*SW_NUM`: switch levels, bank i in bits `[8i+7:8i]`.
- `bt_in` input `BT_NUM`: raw button levels.
- `kb_idx` input 5: bit4 is key-valid level, `[3:0]` is the key code.
- `led_out` output `8*LED_NUM`: LED registers.
- `seg_out` output 32: seven-segment register.

## Operation
Register map, as offsets from `0xFFFF_FF00`:
- `0x00+4i`, i<`SW_NUM`: SW[i], read-only, `{24'h0, sw_in bank i}`. Not synchronised.
- `0x20+4i`, i<`LED_NUM`: LED[i], read/write `[7:0]`. Reads return the register value.
- `0x30` SEG: read/write, 32 bits.
- `0x34` BT_LVL: read-only, synchronised button levels, zero-extended.
- `0x38` BT_EVT: sticky rising-edge flags per button.
  - A read with `reb` clears the bits returned.
  - A write clears the bits where `write_datab` is 1 (write-1-to-clear).
- `0x3C` KB_DATA: read returns `{23'h0, valid, 4'h0, key}`, where valid = FIFO non-empty and key = head entry.
  - A read with `reb` while non-empty pops the head.
  - A read while empty returns 0 with no effect.
- `0x40` KB_STAT: read-only, `{15'h0, ovf, 6'h0, full, empty, cnt[7:0]}`. A read with `reb` clears `ovf`.
- Anything else in the window: reads return 0, writes are ignored.

Input handling:
- `bt_in` and `kb_idx` each pass through a 2-flop synchroniser.
- Edge detection compares the synchronised value with a third, delayed flop.
- A rising edge of synchronised `kb_idx[4]` pushes synchronised `kb_idx[3:0]` into the FIFO.

FIFO:
- Circular buffer with read and write pointers of width `$clog2(KB_DEPTH)`; both wrap modulo `KB_DEPTH`.
- Count width is `$clog2(KB_DEPTH)+1`.

Boundary and priority rules:
- `web` and `reb` both high: the write is performed and read side effects are suppressed.
- Edge set and clear on the same bit in the same cycle: the set wins.
- Push and pop in the same cycle while non-empty: both happen and the count is unchanged. This includes the full case, and it does not set `ovf`.
- Push while empty with a pop attempt: only the push happens.
- Push while full without a pop: the key is dropped and `ovf` is set. If the `ovf` set coincides with a status read, the set wins.
- Side effects apply only when `io_hit` is high.

## Timing
- `datab_io` and `io_hit` are combinational from `addrb` and current state, with zero latency.
- Writes, clears and pops take effect on the `clkb` edge that ends the strobe cycle. A read in the next cycle sees the new state.
- Button or key latency: an input edge arriving before edge n is visible in BT_EVT or KB_DATA at the read in cycle n+3.

Reset (`rst` high at an edge) sets all of the following to zero:
- `led_out`, `seg_out`, BT_EVT, `ovf`;
- FIFO pointers and count, giving empty=1 and full=0;
- all synchroniser and edge flops.

Reset wins over any simultaneous write, push or pop. Keys in flight are discarded.

## Configuration
`MMIO_TIMER_EN`:
- Defined: offset `0x44` is TIMER, a 32-bit free-running cycle counter.
  - Resets to 0 and increments every `clkb`, wrapping at `2^32`.
  - A write loads `write_datab`; the following cycle reads `write_datab+1`.
- Undefined: the counter is absent and `0x44` is unmapped (reads return 0).

## Test plan
- Reset, then write `0xA5` to `0xFFFF_FF24` → `led_out[15:8]=0xA5` next cycle and `led_out[7:0]=0`. Read of `0xFFFF_FF30` = 0.
- Pulse `bt_in[2]` for 5 cycles → BT_EVT = `0x04` after 3 cycles. Read with `reb` → next read = 0. Edge in the same cycle as the clear → stays `0x04`.
- Push keys 1,2,3,4 (`KB_DEPTH`=4), then a fifth key 9 → KB_STAT = `0x0001_0204`.
  - Pops return `0x101`, `0x102`, `0x103`, `0x104`; the next pop returns 0.
  - KB_STAT reads `ovf`=0 after the first status read.
- FIFO full, with a simultaneous push of 7 and a pop → count stays 4 and `ovf`=0. The last entry read out is 7.
- Assert `rst` with 2 keys queued and `seg`=`0x1234` → KB_STAT = `0x0000_0100`, `seg_out`=0.
- With `MMIO_TIMER_EN`: write `0xFFFF_FFFE` to `0x44` → reads `0xFFFF_FFFF`, then 0 one cycle later (wrap).
